// File: rtl/interrupt_ctrl.sv
// Machine-level interrupt controller: builds mip, masks with mie/gie, and hands the
// winning cause to the trap unit via req/ack. MEIP path built only with INTERRUPT_CTRL_EXT_IRQ_EN.
module interrupt_ctrl #(
    parameter int DATA_SIZE       = 64,
    parameter int EXT_SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] msip,
    input  logic [63:0]          mtime,
    input  logic [63:0]          mtimecmp,
    input  logic                 external_interrupt,
    input  logic [DATA_SIZE-1:0] mie,
    input  logic                 mstatus_mie,
    input  logic [1:0]           privilege,
    input  logic                 irq_ack,
    input  logic                 trap_return,
    output logic [DATA_SIZE-1:0] mip,
    output logic                 irq_req,
    output logic [DATA_SIZE-1:0] irq_cause
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_TAKEN
    } state_t;

    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;
    localparam logic [3:0] CODE_MEI = 4'd11;

    state_t     r_state;
    logic [3:0] r_code;
    logic       r_msip;
    logic       r_hi_gt;
    logic       r_hi_eq;
    logic       r_lo_ge;
    logic       r_mtip;
    logic       w_meip;
    logic       w_gie;
    logic       w_act_msi;
    logic       w_act_mti;
    logic       w_act_mei;
    logic       w_any_active;
    logic       w_latched_active;
    logic [3:0] w_sel_code;
    logic       w_unused_bits;

    function automatic logic [DATA_SIZE-1:0] cause_of(input logic [3:0] code);
        cause_of = '0;
        cause_of[DATA_SIZE-1] = 1'b1;
        cause_of[3:0] = code;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_msip  <= 1'b0;
            r_hi_gt <= 1'b0;
            r_hi_eq <= 1'b0;
            r_lo_ge <= 1'b0;
            r_mtip  <= 1'b0;
        end else begin
            r_msip  <= msip[0];
            r_hi_gt <= mtime[63:32] > mtimecmp[63:32];
            r_hi_eq <= mtime[63:32] == mtimecmp[63:32];
            r_lo_ge <= mtime[31:0] >= mtimecmp[31:0];
            r_mtip  <= r_hi_gt | (r_hi_eq & r_lo_ge);
        end
    end

`ifdef INTERRUPT_CTRL_EXT_IRQ_EN
    logic [EXT_SYNC_STAGES-1:0] r_ext_sync;
    logic                       r_meip;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ext_sync <= '0;
            r_meip     <= 1'b0;
        end else begin
            r_ext_sync <= {r_ext_sync[EXT_SYNC_STAGES-2:0], external_interrupt};
            r_meip     <= r_ext_sync[EXT_SYNC_STAGES-1];
        end
    end

    assign w_meip = r_meip;
`else
    assign w_meip = 1'b0;
`endif

    assign w_unused_bits = ^{msip[DATA_SIZE-1:1], mie, external_interrupt, EXT_SYNC_STAGES[0]};

    always_comb begin
        mip     = '0;
        mip[3]  = r_msip;
        mip[7]  = r_mtip;
        mip[11] = w_meip;
    end

    assign w_gie        = mstatus_mie | (privilege != 2'b11);
    assign w_act_msi    = r_msip & mie[3];
    assign w_act_mti    = r_mtip & mie[7];
    assign w_act_mei    = w_meip & mie[11];
    assign w_any_active = w_act_msi | w_act_mti | w_act_mei;

    always_comb begin
        w_sel_code = CODE_MTI;
        if (w_act_mei) begin
            w_sel_code = CODE_MEI;
        end else if (w_act_msi) begin
            w_sel_code = CODE_MSI;
        end
    end

    // Withdrawal only tracks the source that was latched, not whichever is now highest.
    always_comb begin
        w_latched_active = 1'b0;
        case (r_code)
            CODE_MEI: w_latched_active = w_act_mei;
            CODE_MSI: w_latched_active = w_act_msi;
            CODE_MTI: w_latched_active = w_act_mti;
            default:  w_latched_active = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_code    <= '0;
            irq_req   <= 1'b0;
            irq_cause <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gie && w_any_active) begin
                        r_state   <= S_REQ;
                        r_code    <= w_sel_code;
                        irq_req   <= 1'b1;
                        irq_cause <= cause_of(w_sel_code);
                    end
                end
                S_REQ: begin
                    if (irq_ack) begin
                        r_state <= S_TAKEN;
                        irq_req <= 1'b0;
                    end else if (!w_latched_active || !w_gie) begin
                        r_state   <= S_IDLE;
                        irq_req   <= 1'b0;
                        irq_cause <= '0;
                    end
                end
                S_TAKEN: begin
                    if (trap_return) begin
                        r_state   <= S_IDLE;
                        irq_cause <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    irq_req   <= 1'b0;
                    irq_cause <= '0;
                end
            endcase
        end
    end

endmodule
